// File: rtl/lpc_sink_pkg.sv
// Shared widths, FSM state encoding and length helper for the LPC sink RAM writer.
package lpc_sink_pkg;

  localparam int LPC_DATA_W = 16;
  localparam int LPC_ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } lpc_state_t;

  // A programmed length of zero means "fill the whole RAM".
  function automatic int unsigned lpc_expand_len(input int unsigned len,
                                                 input int unsigned addr_w);
    return (len == 0) ? (32'd1 << addr_w) : len;
  endfunction

endpackage

// File: rtl/lpc_avmm_wr_stage.sv
// One-entry Avalon-MM write register: loads a word, holds it under waitrequest,
// and empties once the slave accepts it. A load in the drain cycle refills it.
module lpc_avmm_wr_stage
  import lpc_sink_pkg::*;
#(
  parameter int DATA_W = LPC_DATA_W,
  parameter int ADDR_W = LPC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_waitrequest,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_writedata,
  output logic              o_full,
  output logic              o_drain
);

  logic              r_write;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writedata;

  assign o_write     = r_write;
  assign o_address   = r_address;
  assign o_writedata = r_writedata;
  assign o_full      = r_write;
  assign o_drain     = r_write & ~i_waitrequest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
    end else if (i_load) begin
      r_write     <= 1'b1;
      r_address   <= i_addr;
      r_writedata <= i_data;
    end else if (o_drain) begin
      r_write <= 1'b0;
    end
  end

endmodule

// File: rtl/lpc_sink_ram_writer.sv
// Drains a 16-bit stream into a window of the LPC sink RAM through an Avalon-MM
// write master; stops on word count or end-of-packet.
module lpc_sink_ram_writer
  import lpc_sink_pkg::*;
#(
  parameter int DATA_W = LPC_DATA_W,
  parameter int ADDR_W = LPC_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  input  logic                snk_eop,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                eop_stop,
  output lpc_state_t          dbg_state
);

  localparam int LW = ADDR_W + 1;

  lpc_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_word_count;
  logic              r_busy, r_done, r_eop_stop;
  logic              w_full, w_drain, w_load_ok, w_accept, w_start_ok, w_last, w_finish;

  // Handshakes: a stream sample transfers on a rising edge where snk_valid and
  // snk_ready are both high; a bus write transfers on a rising edge where
  // m_write is high and m_waitrequest is low, and is held unchanged until then.
  assign w_load_ok  = (r_state == ST_RUN) && (r_remaining != '0) && (!w_full || w_drain);
  assign w_accept   = snk_valid && w_load_ok;
  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_last     = snk_eop || (r_remaining == LW'(1));
  assign w_finish   = (r_state == ST_FLUSH) && w_drain;

  assign snk_ready    = w_load_ok;
  assign m_chipselect = m_write;
  assign m_byteenable = {(DATA_W/8){m_write}};
  assign busy         = r_busy;
  assign done         = r_done;
  assign word_count   = r_word_count;
  assign eop_stop     = r_eop_stop;
  assign dbg_state    = r_state;

  lpc_avmm_wr_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_stage (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_accept),
    .i_addr       (r_wr_ptr),
    .i_data       (snk_data),
    .i_waitrequest(m_waitrequest),
    .o_write      (m_write),
    .o_address    (m_address),
    .o_writedata  (m_writedata),
    .o_full       (w_full),
    .o_drain      (w_drain)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_drain) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_remaining  <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_eop_stop   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) r_busy <= 1'b0;
      if (w_start_ok) begin
        r_wr_ptr     <= base_addr;
        r_remaining  <= LW'(lpc_expand_len(32'(length), ADDR_W));
        r_word_count <= '0;
        r_eop_stop   <= 1'b0;
        r_busy       <= 1'b1;
      end else begin
        if (w_drain) r_word_count <= r_word_count + LW'(1);
        if (w_accept) begin
          r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
          r_remaining <= r_remaining - LW'(1);
          // Early packet end only counts when words were still owed.
          if (snk_eop && (r_remaining > LW'(1))) r_eop_stop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpc_sink_ram_writer.sv
// Randomized bench for lpc_sink_ram_writer: expected bus writes come from the
// capture rules (base+i mod depth, stop at length or eop) held in a queue.
module tb_lpc_sink_ram_writer;
  import lpc_sink_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     length = '0;
  logic [DW-1:0]   snk_data = '0;
  logic            snk_valid = 1'b0;
  logic            snk_eop = 1'b0;
  logic            snk_ready;
  logic [AW-1:0]   m_address;
  logic            m_chipselect;
  logic            m_write;
  logic [DW-1:0]   m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic            m_waitrequest = 1'b0;
  logic            busy, done, eop_stop;
  logic [AW:0]     word_count;
  lpc_state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  int               wr_cyc_q[$];
  logic [DW-1:0]    samp[4096];
  int               cov[DEPTH];
  int               cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int               wait_mode = 0, wait_hits = 0, tgt_cycles = 0;
  logic [AW-1:0]    tgt_addr = '0;
  logic             held_v = 1'b0;
  logic [AW+DW-1:0] held, mon_e;
  logic             abort = 1'b0;

  lpc_sink_ram_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .busy(busy), .done(done), .word_count(word_count), .eop_stop(eop_stop),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_snk_ready"},    32'(snk_ready),    32'd0);
    check({pfx, "_m_write"},      32'(m_write),      32'd0);
    check({pfx, "_m_chipselect"}, 32'(m_chipselect), 32'd0);
    check({pfx, "_m_address"},    32'(m_address),    32'd0);
    check({pfx, "_m_writedata"},  32'(m_writedata),  32'd0);
    check({pfx, "_m_byteenable"}, 32'(m_byteenable), 32'd0);
    check({pfx, "_busy"},         32'(busy),         32'd0);
    check({pfx, "_done"},         32'(done),         32'd0);
    check({pfx, "_word_count"},   32'(word_count),   32'd0);
    check({pfx, "_eop_stop"},     32'(eop_stop),     32'd0);
  endtask

  // ---------------- slave waitrequest model ----------------
  always begin
    @(negedge clk);
    case (wait_mode)
      1: m_waitrequest = ($urandom_range(0, 99) < 30);
      2: begin
        if (m_write && m_address == tgt_addr && wait_hits < 2) begin
          m_waitrequest = 1'b1;
          wait_hits++;
        end else begin
          m_waitrequest = 1'b0;
        end
      end
      default: m_waitrequest = 1'b0;
    endcase
  end

  // ---------------- bus monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_stable", 32'({m_write, m_address, m_writedata}), 32'({1'b1, held}));
        held_v = 1'b0;
      end
      if (m_write) check("cs_be", 32'({m_chipselect, m_byteenable}), 32'h7);
      if (m_write && m_waitrequest) begin
        held_v = 1'b1;
        held   = {m_address, m_writedata};
        check("ready_blocked", 32'(snk_ready), 32'd0);
      end
      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(m_address), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(m_address),   32'(mon_e[AW+DW-1:DW]));
          check("wr_data", 32'(m_writedata), 32'(mon_e[DW-1:0]));
        end
        cov[m_address]++;
        wr_cnt++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
      end
      if (m_write && m_address == tgt_addr) tgt_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) samp[i] = DW'($urandom);
  endtask

  task automatic drive_stream(input int n, input int eop_idx, input int gap);
    bit acc;
    int guard;
    for (int i = 0; i < n && !abort; i++) begin
      @(negedge clk);
      while (gap > 0 && $urandom_range(0, 99) < gap && !abort) begin
        snk_valid = 1'b0;
        @(negedge clk);
      end
      snk_valid = 1'b1;
      snk_data  = samp[i];
      snk_eop   = (i == eop_idx);
      acc   = 1'b0;
      guard = 0;
      while (!acc && !abort && guard < 3000) begin
        #4;
        acc = snk_ready;
        if (!acc) begin
          @(negedge clk);
          guard++;
        end
      end
      if (!acc && !abort) check("sample_accept_timeout", 32'd0, 32'd1);
      if (!acc) break;
      @(posedge clk);
    end
    @(negedge clk);
    snk_valid = 1'b0;
    snk_eop   = 1'b0;
    if (!abort) begin
      #4;
      check("ready_after_last", 32'(snk_ready), 32'd0);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int len);
    @(negedge clk);
    base_addr = base;
    length    = (AW+1)'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #4;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic push_expected(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(base) + i) % DEPTH);
      exp_q.push_back({a, samp[i]});
    end
  endtask

  task automatic run_capture(input logic [AW-1:0] base, input int len, input int eop_idx,
                             input int gap, input bit extra_start);
    int len_eff, n, d0, g;
    bit exp_eop;
    len_eff = (len == 0) ? DEPTH : len;
    n       = (eop_idx >= 0 && eop_idx < len_eff) ? eop_idx + 1 : len_eff;
    exp_eop = (eop_idx >= 0 && eop_idx + 1 < len_eff);
    push_expected(base, n);
    d0 = done_cnt;
    pulse_start(base, len);
    fork
      drive_stream(n, eop_idx, gap);
      begin
        if (extra_start) begin
          repeat (3) @(negedge clk);
          if (busy) begin
            base_addr = AW'($urandom);
            length    = (AW+1)'($urandom_range(1, 50));
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
          end
        end
      end
    join
    g = 0;
    while (done_cnt == d0 && g < 6000) begin
      @(posedge clk);
      g++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #4;
    check("done_once",    32'(done_cnt - d0),    32'd1);
    check("done_timing",  32'(done_cyc),         32'(last_wr_cyc + 1));
    check("word_count",   32'(word_count),       32'(n));
    check("eop_stop",     32'(eop_stop),         32'(exp_eop));
    check("busy_cleared", 32'(busy),             32'd0);
    check("exp_drained",  32'(exp_q.size()),     32'd0);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g, d0, bad, len, eop_idx;
    logic [AW-1:0] base;

    repeat (3) @(negedge clk);
    #4;
    check_reset_outputs("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #4;
    check_reset_outputs("after_reset");
    check("state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // samples ignored while idle
    @(negedge clk);
    snk_valid = 1'b1;
    #4;
    check("idle_not_ready", 32'(snk_ready), 32'd0);
    @(negedge clk);
    snk_valid = 1'b0;

    // back-to-back fixed pattern from base 0
    for (int i = 0; i < 4; i++) samp[i] = DW'(16'h1111 * (i + 1));
    wr_cyc_q.delete();
    run_capture(11'h000, 4, -1, 0, 1'b0);
    for (int i = 1; i < 4; i++)
      check("b2b_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);

    // address wrap at top of RAM
    fill_random(4);
    run_capture(11'h7FE, 4, -1, 0, 1'b0);

    // early end of packet
    fill_random(8);
    run_capture(11'h100, 8, 2, 0, 1'b0);

    // waitrequest held on the second write
    fill_random(3);
    wait_mode  = 2;
    wait_hits  = 0;
    tgt_addr   = 11'h041;
    tgt_cycles = 0;
    run_capture(11'h040, 3, -1, 0, 1'b0);
    check("wait_hold_cycles", 32'(tgt_cycles), 32'd3);
    wait_mode = 0;

    // whole-RAM capture from a nonzero base with stalls on both sides
    for (int i = 0; i < DEPTH; i++) cov[i] = 0;
    fill_random(DEPTH);
    wait_mode = 1;
    run_capture(11'h005, 0, -1, 30, 1'b0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cov[i] != 1) bad++;
    check("full_coverage", 32'(bad), 32'd0);
    wait_mode = 0;

    // reset in the middle of a capture
    fill_random(6);
    push_expected(11'h123, 6);
    d0 = wr_cnt;
    pulse_start(11'h123, 6);
    fork
      drive_stream(6, -1, 0);
      begin
        g = 0;
        while (wr_cnt < d0 + 2 && g < 200) begin
          @(posedge clk);
          g++;
        end
        check("reset_wait", 32'(wr_cnt >= d0 + 2), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        abort = 1'b1;
      end
    join
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    fill_random(5);
    run_capture(11'h3A0, 5, -1, 0, 1'b0);

    // randomized captures with stalls, early eop and ignored restarts
    wait_mode = 1;
    for (int k = 0; k < 6; k++) begin
      base    = AW'($urandom);
      len     = int'($urandom_range(1, 40));
      eop_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 44)) : -1;
      fill_random(len);
      run_capture(base, len, eop_idx, 25, k[0]);
    end
    wait_mode = 0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
